// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing the Ethernet/IP/UDP TX header path and payload AXIS port among NUM_SRC sources.
// Latency: start 1 cycle after request; payload mux is combinational (zero latency, no buffering).
// Backpressure: m_axis_tready passes straight to the granted source. Optional stall watchdog: ETH_TX_ARB_WDOG_EN.
module eth_tx_arbiter #(
    parameter int NUM_SRC     = 2,
    parameter int DATA_W      = 32,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_SRC-1:0]        src_tx_start,
    input  logic [16*NUM_SRC-1:0]     src_udp_len,
    output logic [NUM_SRC-1:0]        src_hdr_done,
    output logic                      eth_header_ip_tx_start,
    input  logic                      udp_header_tx_done,
    output logic [15:0]               udp_len,
    input  logic [DATA_W*NUM_SRC-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready
`ifdef ETH_TX_ARB_WDOG_EN
    ,
    output logic                      wdog_abort
`endif
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_HDR, ST_DATA, ST_GAP} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [15:0]        udp_len_q, udp_len_d;
    logic               start_q, start_d;
    logic [NUM_SRC-1:0] hdr_done_q, hdr_done_d;
    logic [GW-1:0]      pick, idx_l, next_ptr;
    logic               pick_vld;
    logic               beat;
    logic               stall_abort;
    int                 idx;

    // Search rr_ptr, rr_ptr+1, ... ; iterating downward lets the earliest hit win.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        idx_l    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx_l = GW'(idx);
            if (src_tx_start[idx_l]) begin
                pick     = idx_l;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        next_ptr = '0;
        if (int'(grant_q) != NUM_SRC - 1) next_ptr = grant_q + GW'(1);
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == ST_DATA) begin
            m_axis_tdata           = s_axis_tdata[grant_q*DATA_W +: DATA_W];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign beat = m_axis_tvalid & m_axis_tready;

`ifdef ETH_TX_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES) + 1;
    logic [CW-1:0] wdog_cnt_q, wdog_cnt_d;

    // The count runs across WAIT_HDR into DATA; only a grant or a payload beat restarts it.
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        stall_abort = 1'b0;
        if (state_q == ST_IDLE && pick_vld) begin
            wdog_cnt_d = '0;
        end else if (state_q == ST_WAIT_HDR || state_q == ST_DATA) begin
            if (wdog_cnt_q == CW'(WDOG_CYCLES - 1) && !beat) stall_abort = 1'b1;
            else if (beat)                                   wdog_cnt_d  = '0;
            else                                             wdog_cnt_d  = wdog_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) wdog_cnt_q <= '0;
        else        wdog_cnt_q <= wdog_cnt_d;
    end

    assign wdog_abort = stall_abort;
`else
    assign stall_abort = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        udp_len_d  = udp_len_q;
        start_d    = start_q;
        hdr_done_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick;
                    udp_len_d = src_udp_len[pick*16 +: 16];
                    start_d   = 1'b1;
                    state_d   = ST_WAIT_HDR;
                end
            end
            ST_WAIT_HDR: begin
                if (stall_abort) begin
                    start_d  = 1'b0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_GAP;
                end else if (udp_header_tx_done) begin
                    start_d             = 1'b0;
                    hdr_done_d[grant_q] = 1'b1;
                    state_d             = ST_DATA;
                end
            end
            ST_DATA: begin
                if (stall_abort || (beat && m_axis_tlast)) begin
                    rr_ptr_d = next_ptr;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            udp_len_q  <= '0;
            start_q    <= 1'b0;
            hdr_done_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            udp_len_q  <= udp_len_d;
            start_q    <= start_d;
            hdr_done_q <= hdr_done_d;
        end
    end

    assign udp_len                = udp_len_q;
    assign eth_header_ip_tx_start = start_q;
    assign src_hdr_done           = hdr_done_q;

endmodule
